// File: rtl/psram_burst_ctrl_param.sv
// psram_burst_ctrl_param
// Runs one logical read or write burst against a synchronous burst PSRAM.
// A request (start address, direction, word count) becomes one or more
// physical bursts. The controller closes a burst and re-addresses whenever
// CE# would otherwise stay low longer than CEM_MAX cycles.
//
// Ports
//   clk_i, rst_i          system clock; asynchronous active-low reset
//   start_i/we_i/adr_i/len_i
//                         request, sampled in IDLE (len_i=0 -> 2^LW words)
//   wr_dat_i, wr_rdy_o    write stream; a word is taken in each cycle that
//                         wr_rdy_o is high
//   rd_dat_o, rd_vld_o    read stream, one pulse per word, no backpressure
//   busy_o, done_o        request in progress / one-cycle completion pulse
//   psram_*               PSRAM pad side (clock, address, data, strobes)
module psram_burst_ctrl_param #(
    parameter int DW      = 16,
    parameter int AW      = 23,
    parameter int LW      = 8,
    parameter int LATENCY = 3,   // >= 1
    parameter int CEM_MAX = 32   // >= LATENCY+2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          we_i,
    input  logic [AW-1:0] adr_i,
    input  logic [LW-1:0] len_i,
    input  logic [DW-1:0] wr_dat_i,
    output logic          wr_rdy_o,
    output logic [DW-1:0] rd_dat_o,
    output logic          rd_vld_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          psram_clk,
    output logic [AW-1:0] psram_adr,
    output logic [DW-1:0] psram_dat_o,
    input  logic [DW-1:0] psram_dat_i,
    output logic          psram_data_oe,
    output logic          psram_we_n,
    output logic          psram_ce_n,
    output logic          psram_adv_n,
    output logic          psram_oe_n
);

    localparam int CW = $clog2(CEM_MAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_LAT   = 3'd2;
    localparam logic [2:0] S_XFER  = 3'd3;
    localparam logic [2:0] S_RECOV = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_nxt;
    logic          r_we;
    logic [AW-1:0] r_adr;
    logic [LW:0]   r_rem;     // one extra bit so len_i=0 can hold 2^LW
    logic [CW-1:0] r_cem;     // cycles CE# has been low in this segment
    logic          r_clk_en;
    logic          r_busy;
    logic          r_done;
    logic          r_rd_vld;
    logic [DW-1:0] r_rd_dat;
    logic [DW-1:0] r_pdat;

    logic w_addr, w_lat, w_xfer;
    logic w_last_word, w_seg_end, w_lat_last, w_wr_rdy;

    assign w_addr = (r_state == S_ADDR);
    assign w_lat  = (r_state == S_LAT);
    assign w_xfer = (r_state == S_XFER);

    // r_cem is 1 in ADDR, so the last LAT cycle sits at LATENCY+1 and the
    // segment may transfer until the counter reaches CEM_MAX.
    assign w_lat_last  = w_lat  && (r_cem == CW'(LATENCY + 1));
    assign w_last_word = w_xfer && (r_rem == (LW+1)'(1));
    assign w_seg_end   = w_xfer && (r_cem == CW'(CEM_MAX));

    // Prefetch the first word in the last LAT cycle, then one word per XFER
    // cycle except the last of the segment (its word was taken a cycle ago).
    assign w_wr_rdy = r_we && (w_lat_last || (w_xfer && !w_last_word && !w_seg_end));

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_nxt = S_ADDR;
            S_ADDR:  w_nxt = S_LAT;
            S_LAT:   if (w_lat_last) w_nxt = S_XFER;
            S_XFER: begin
                if (w_last_word)    w_nxt = S_IDLE;
                else if (w_seg_end) w_nxt = S_RECOV;
            end
            S_RECOV: w_nxt = S_ADDR;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_rem    <= '0;
            r_cem    <= '0;
            r_clk_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rd_vld <= 1'b0;
            r_rd_dat <= '0;
            r_pdat   <= '0;
        end else begin
            r_state  <= w_nxt;
            r_clk_en <= (w_nxt == S_ADDR) || (w_nxt == S_LAT) || (w_nxt == S_XFER);
            r_done   <= w_last_word;
            r_rd_vld <= w_xfer && !r_we;
            if (w_xfer && !r_we) r_rd_dat <= psram_dat_i;
            if (w_wr_rdy)        r_pdat   <= wr_dat_i;

            if (w_nxt == S_ADDR)           r_cem <= CW'(1);
            else if (w_addr || w_lat || w_xfer) r_cem <= r_cem + CW'(1);

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_we   <= we_i;
                        r_adr  <= adr_i;
                        r_rem  <= (len_i == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, len_i};
                        r_busy <= 1'b1;
                    end
                end
                S_XFER: begin
                    // Address wraps naturally at 2^AW.
                    r_adr <= r_adr + AW'(1);
                    r_rem <= r_rem - (LW+1)'(1);
                    if (w_last_word) r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign wr_rdy_o      = w_wr_rdy;
    assign rd_dat_o      = r_rd_dat;
    assign rd_vld_o      = r_rd_vld;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign psram_clk     = r_clk_en & ~clk_i;
    assign psram_adr     = r_adr;
    assign psram_dat_o   = r_pdat;
    assign psram_data_oe = w_xfer && r_we;
    assign psram_ce_n    = !(w_addr || w_lat || w_xfer);
    assign psram_adv_n   = !w_addr;
    assign psram_we_n    = !(w_addr && r_we);
    assign psram_oe_n    = !((w_lat || w_xfer) && !r_we);

endmodule

// File: tb/tb_psram_burst_ctrl_param.sv
// Scoreboard bench for psram_burst_ctrl_param (default parameters).
// Stimulus pushes expected ADDR cycles, write words, read words and CE#-low
// run lengths into queues; a monitor pops and compares as the DUT shows them.
module tb_psram_burst_ctrl_param;

    localparam int DW = 16;
    localparam int AW = 23;
    localparam int LW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i, we_i;
    logic [AW-1:0] adr_i;
    logic [LW-1:0] len_i;
    logic [DW-1:0] wr_dat_i;
    logic          wr_rdy_o;
    logic [DW-1:0] rd_dat_o;
    logic          rd_vld_o, busy_o, done_o, psram_clk;
    logic [AW-1:0] psram_adr;
    logic [DW-1:0] psram_dat_o, psram_dat_i;
    logic          psram_data_oe, psram_we_n, psram_ce_n, psram_adv_n, psram_oe_n;

    psram_burst_ctrl_param dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .we_i(we_i),
        .adr_i(adr_i), .len_i(len_i), .wr_dat_i(wr_dat_i), .wr_rdy_o(wr_rdy_o),
        .rd_dat_o(rd_dat_o), .rd_vld_o(rd_vld_o), .busy_o(busy_o), .done_o(done_o),
        .psram_clk(psram_clk), .psram_adr(psram_adr), .psram_dat_o(psram_dat_o),
        .psram_dat_i(psram_dat_i), .psram_data_oe(psram_data_oe),
        .psram_we_n(psram_we_n), .psram_ce_n(psram_ce_n),
        .psram_adv_n(psram_adv_n), .psram_oe_n(psram_oe_n)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wexp_t;
    typedef struct { logic [AW-1:0] a; logic we; } aexp_t;

    wexp_t         q_wr[$];
    aexp_t         q_addr[$];
    logic [DW-1:0] q_rd[$];
    int            q_ce[$];

    int nvec = 0, nerr = 0;
    int taken = 0, wstart = 0, done_cnt = 0, oe_cyc = 0, recov_cyc = 0;
    logic [DW-1:0] wbase = '0, rbase = 16'hA000;
    logic [AW-1:0] rstart = '0;

    // Write source: word n of the current request is wbase+n.
    assign wr_dat_i    = wbase + DW'(taken - wstart);
    // Memory model: word at rstart+n reads as rbase+n.
    assign psram_dat_i = rbase + DW'(psram_adr - rstart);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic underflow(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s: unexpected DUT output at %0t", nm, $time);
    endtask

    task automatic monitor();
        int run = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                run = 0;
                continue;
            end
            if (!psram_ce_n) run++;
            else if (run != 0) begin
                if (q_ce.size() == 0) underflow("ce_run");
                else chk("ce_low_len", run, q_ce.pop_front());
                run = 0;
            end
            if (psram_ce_n && busy_o) recov_cyc++;
            if (!psram_oe_n) oe_cyc++;
            if (!psram_adv_n) begin
                if (q_addr.size() == 0) underflow("addr_cycle");
                else begin
                    aexp_t e = q_addr.pop_front();
                    chk("addr_adr", psram_adr, e.a);
                    chk("addr_we_n", psram_we_n, !e.we);
                end
            end
            if (psram_data_oe) begin
                if (q_wr.size() == 0) underflow("wr_word");
                else begin
                    wexp_t e = q_wr.pop_front();
                    chk("wr_adr", psram_adr, e.a);
                    chk("wr_dat", psram_dat_o, e.d);
                end
            end
            if (rd_vld_o) begin
                if (q_rd.size() == 0) underflow("rd_word");
                else chk("rd_dat", rd_dat_o, q_rd.pop_front());
            end
            if (done_o) begin
                done_cnt++;
                chk("done_busy", busy_o, 0);
                chk("done_ce_n", psram_ce_n, 1);
            end
        end
    endtask

    task automatic driver();
        logic t;
        forever begin
            @(negedge clk_i);
            t = wr_rdy_o && rst_i;
            @(posedge clk_i);
            #1;
            if (t) taken++;
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int n);
        for (int i = 0; i < n; i++) q_wr.push_back('{a: a + AW'(i), d: d + DW'(i)});
    endtask

    task automatic push_rd(input logic [DW-1:0] d, input int n);
        for (int i = 0; i < n; i++) q_rd.push_back(d + DW'(i));
    endtask

    task automatic req(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] n, input logic hold);
        @(posedge clk_i);
        #1;
        start_i = 1'b1;
        we_i    = we;
        adr_i   = a;
        len_i   = n;
        if (!hold) begin
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (done_o) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk_i);
    endtask

    task automatic stimulus();
        int d0, t0, o0, r0, cnt;

        // Write, 4 words at 0x12D687
        wbase = 16'h0059; wstart = taken;
        q_addr.push_back('{a: 23'h12D687, we: 1'b1});
        push_wr(23'h12D687, 16'h0059, 4);
        q_ce.push_back(8);
        d0 = done_cnt; t0 = taken;
        req(1'b1, 23'h12D687, 8'd4, 1'b0);
        wait_done(100);
        settle();
        chk("t1_wr_rdy_cnt", taken - t0, 4);
        chk("t1_done_cnt", done_cnt - d0, 1);

        // Read, 3 words at 0x000010
        rstart = 23'h000010;
        q_addr.push_back('{a: 23'h000010, we: 1'b0});
        push_rd(16'hA000, 3);
        q_ce.push_back(7);
        d0 = done_cnt; o0 = oe_cyc;
        req(1'b0, 23'h000010, 8'd3, 1'b0);
        wait_done(100);
        chk("t2_final_vld_with_done", rd_vld_o, 1);
        settle();
        chk("t2_oe_cycles", oe_cyc - o0, 6);
        chk("t2_done_cnt", done_cnt - d0, 1);

        // CE#-limited write split: 28 + 12 words
        wbase = 16'h0100; wstart = taken;
        q_addr.push_back('{a: 23'h000000, we: 1'b1});
        q_addr.push_back('{a: 23'h00001C, we: 1'b1});
        push_wr(23'h000000, 16'h0100, 40);
        q_ce.push_back(32);
        q_ce.push_back(16);
        d0 = done_cnt; t0 = taken; r0 = recov_cyc;
        req(1'b1, 23'h000000, 8'd40, 1'b0);
        wait_done(200);
        settle();
        chk("t3_wr_rdy_cnt", taken - t0, 40);
        chk("t3_done_cnt", done_cnt - d0, 1);
        chk("t3_recov_cycles", recov_cyc - r0, 1);

        // Address wrap across 2^AW, read of 4 words
        rstart = 23'h7FFFFE;
        q_addr.push_back('{a: 23'h7FFFFE, we: 1'b0});
        push_rd(16'hA000, 4);
        q_ce.push_back(8);
        o0 = oe_cyc;
        req(1'b0, 23'h7FFFFE, 8'd4, 1'b0);
        wait_done(100);
        chk("t4_end_adr", psram_adr, 23'h000002);
        settle();
        chk("t4_oe_cycles", oe_cyc - o0, 7);

        // Reset during the 2nd XFER cycle of an 8-word write
        wbase = 16'h0300; wstart = taken;
        q_addr.push_back('{a: 23'h000200, we: 1'b1});
        push_wr(23'h000200, 16'h0300, 2);
        req(1'b1, 23'h000200, 8'd8, 1'b0);
        cnt = 0;
        for (int i = 0; i < 50 && cnt < 2; i++) begin
            @(negedge clk_i);
            if (psram_data_oe) cnt++;
        end
        chk("t5_reach_xfer2", cnt, 2);
        #1 rst_i = 1'b0;
        #1;
        chk("rst_ce_n", psram_ce_n, 1);
        chk("rst_we_n", psram_we_n, 1);
        chk("rst_adv_n", psram_adv_n, 1);
        chk("rst_oe_n", psram_oe_n, 1);
        chk("rst_data_oe", psram_data_oe, 0);
        chk("rst_psram_clk", psram_clk, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rd_vld", rd_vld_o, 0);
        chk("rst_wr_rdy", wr_rdy_o, 0);
        chk("rst_adr", psram_adr, 0);
        chk("rst_dat_o", psram_dat_o, 0);
        chk("rst_rd_dat", rd_dat_o, 0);
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("post_rst_ce_n", psram_ce_n, 1);
            chk("post_rst_busy", busy_o, 0);
        end

        // start_i held high, dropped at done: exactly one 2-word read
        rstart = 23'h000040;
        q_addr.push_back('{a: 23'h000040, we: 1'b0});
        push_rd(16'hA000, 2);
        q_ce.push_back(6);
        d0 = done_cnt;
        req(1'b0, 23'h000040, 8'd2, 1'b1);
        wait_done(100);
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t6_stays_idle", busy_o, 0);
        end
        chk("t6_done_cnt", done_cnt - d0, 1);

        // start_i still high in the done/IDLE cycle: next request accepted there
        rstart = 23'h000050;
        q_addr.push_back('{a: 23'h000050, we: 1'b0});
        q_addr.push_back('{a: 23'h000050, we: 1'b0});
        push_rd(16'hA000, 1);
        push_rd(16'hA000, 1);
        q_ce.push_back(5);
        q_ce.push_back(5);
        req(1'b0, 23'h000050, 8'd1, 1'b1);
        wait_done(100);
        @(posedge clk_i);
        #1 start_i = 1'b0;
        @(negedge clk_i);
        chk("t7_accept_in_idle", busy_o, 1);
        wait_done(100);
        settle();

        chk("q_addr_empty", q_addr.size(), 0);
        chk("q_wr_empty", q_wr.size(), 0);
        chk("q_rd_empty", q_rd.size(), 0);
        chk("q_ce_empty", q_ce.size(), 0);
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; we_i = 1'b0; adr_i = '0; len_i = '0;
        #2;
        chk("init_ce_n", psram_ce_n, 1);
        chk("init_busy", busy_o, 0);
        chk("init_psram_clk", psram_clk, 0);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        fork
            monitor();
            driver();
        join_none
        stimulus();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/psram_burst_ctrl_param.md
Name: psram_burst_ctrl_param

Overview:
Parametrised next-generation synchronous PSRAM burst controller. Accepts a start address, direction and word count, then runs one logical burst as one or more physical PSRAM bursts. A burst is split automatically whenever the CE#-low time limit (tCEM) would be exceeded. Sits between the system-side data path and the PSRAM pads; it replaces fixed-width, fixed-length burst control.

Parameters:
DW, 16, data bus width in bits
AW, 23, PSRAM word-address width
LW, 8, width of len_i; len_i=0 means 2^LW words
LATENCY, 3, wait cycles between the address cycle and the first data cycle (>=1)
CEM_MAX, 32, maximum consecutive cycles psram_ce_n may be low (must be >= LATENCY+2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; asynchronous, active-low
start_i  in  1  request strobe, sampled only while busy_o=0
we_i  in  1  1=write, 0=read; sampled with start_i
adr_i  in  AW  start word address; sampled with start_i
len_i  in  LW  word count; sampled with start_i
wr_dat_i  in  DW  write data, consumed when wr_rdy_o=1
wr_rdy_o  out  1  write word taken this cycle
rd_dat_o  out  DW  read data
rd_vld_o  out  1  rd_dat_o valid, 1-cycle pulse per word (no backpressure)
busy_o  out  1  request in progress
done_o  out  1  1-cycle pulse after the final word
psram_clk  out  1  PSRAM clock = clk_en & ~clk_i; clk_en is registered and high from ADDR through XFER
psram_adr  out  AW  PSRAM address
psram_dat_o  out  DW  PSRAM write data (registered)
psram_dat_i  in  DW  PSRAM read data
psram_data_oe  out  1  pad output enable
psram_we_n  out  1  write enable, active-low
psram_ce_n  out  1  chip enable, active-low
psram_adv_n  out  1  address valid, active-low
psram_oe_n  out  1  output enable, active-low

Behaviour:
- Reset (rst_i=0, asynchronous), takes effect immediately, including mid-burst:
  - all state returns to IDLE;
  - ce_n, we_n, adv_n and oe_n go to 1;
  - data_oe, clk_en, busy_o, done_o, rd_vld_o and wr_rdy_o go to 0;
  - psram_adr, psram_dat_o and rd_dat_o go to 0.
- No partial-burst recovery after reset.
- States: IDLE, ADDR, LAT, XFER, RECOV.
- IDLE: if start_i=1, latch we_i, adr_i and len_i, set busy_o=1 and go to ADDR next cycle. start_i is ignored while busy_o=1.
- ADDR (1 cycle):
  - ce_n=0, adv_n=0, psram_adr=current address;
  - we_n=0 if write;
  - CE counter cleared to 1.
- LAT (LATENCY cycles):
  - ce_n=0, adv_n=1;
  - oe_n=0 if read;
  - write: wr_rdy_o=1 in the last LAT cycle (prefetch of the first word).
- XFER (one word per cycle):
  - Write: data_oe=1 and psram_dat_o holds the word captured last cycle. wr_rdy_o=1 in every XFER cycle except the last of the segment.
  - Read: oe_n=0 and psram_dat_i is sampled at the end of the cycle. rd_dat_o and rd_vld_o appear 1 cycle later.
  - Address counter increments each word, modulo 2^AW (0x7FFFFF wraps to 0x000000). Words-remaining counter decrements each word.
- Segment end (last XFER cycle), whichever comes first:
  - remaining words reach 0 → IDLE; done_o pulses on the cycle after, with busy_o=0 and ce_n=1 (reads: aligned with the final rd_vld_o);
  - CE counter reaches CEM_MAX with words left → RECOV.
- RECOV (1 cycle): ce_n=1, clk_en=0, then ADDR with the next address. The data stream continues seamlessly; wr_rdy_o stays low until the new LAT prefetch cycle.
- The CE counter increments every cycle ce_n=0. Words per full segment = CEM_MAX-1-LATENCY.
- len_i=0 means 2^LW words.

Test Plan:
- Write, adr=0x12D687, len=4, wr_dat 0x0059..0x005C:
  - ADDR 1 cycle with we_n=0;
  - 3 LAT cycles;
  - 4 XFER cycles driving 0x0059..0x005C;
  - done_o 1 cycle after the last word; ce_n low for exactly 8 cycles.
- Read, adr=0x000010, len=3, psram_dat_i=0xA000+n:
  - rd_vld_o pulses 3 times, with rd_dat_o 0xA000, 0xA001, 0xA002, each 1 cycle after its XFER cycle;
  - oe_n=0 through LAT and XFER.
- CEM split, write, len=40, CEM_MAX=32:
  - segment 1: 28 words at 0x000000;
  - RECOV: ce_n high 1 cycle;
  - segment 2: ADDR=0x00001C, 12 words;
  - wr_rdy_o total = 40 pulses; done_o once.
- Wrap, read, adr=0x7FFFFE, len=4 → burst at 0x7FFFFE runs 4 words without split and the internal address counter ends at 0x000002.
- Reset low during the 2nd XFER cycle of a len=8 write → all outputs take reset values immediately; after release with start_i=0, remains IDLE with ce_n=1.
- start_i held high through a len=2 read → exactly one request executes; a new start_i is accepted only after done_o, in the IDLE cycle.
